// File: rtl/ewb_queue.sv
// ewb_queue: multi-entry eviction write buffer between the L2 cache and pmem.
// Victim lines are queued in a circular FIFO, read hits are served from the
// buffered copy, and read misses go to pmem. A small FSM drains the entries
// to pmem in FIFO order.
// Optional build macro: EWB_COALESCE_EN. When it is defined, a write to an
// address that is already buffered overwrites that entry in place.
module ewb_queue #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write,
  input  logic              wb_read,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [LINE_W-1:0] wb_wdata,
  output logic              wb_ready,
  output logic              wb_resp,
  output logic [LINE_W-1:0] wb_rdata,
  output logic              wb_empty,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  // Entry storage: valid bits are reset, address/data behave like a RAM.
  logic [DEPTH-1:0]  valid_reg;
  logic [ADDR_W-1:0] addr_reg [DEPTH];
  logic [LINE_W-1:0] data_reg [DEPTH];

  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic              full;
  logic [DEPTH-1:0]  addr_match;
  logic              rd_hit;
  logic [PTR_W-1:0]  rd_hit_idx;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic              wr_accept;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_idx;
  logic              hit_take;

  logic              resp_hit_reg;
  logic [LINE_W-1:0] rdata_reg;

  // Scan entries from oldest (head) to youngest; the last match seen is the
  // youngest one. Valid entries are always contiguous from the head.
  function automatic logic [PTR_W:0] youngest_match(
    input logic [DEPTH-1:0] match,
    input logic [PTR_W-1:0] head
  );
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] idx;
    res = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (match[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign full     = (count_reg == FULL_CNT);
  assign wb_empty = (count_reg == '0);

  // Per-entry address compare against the entries as they stand this cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign addr_match[gi] = valid_reg[gi] && (addr_reg[gi] == wb_address);
  end

  assign {rd_hit, rd_hit_idx} = youngest_match(addr_match, head_reg);

`ifdef EWB_COALESCE_EN
  // The head is frozen while it is being written to pmem, so it is never a
  // coalescing target during DRAIN; such a write allocates a fresh entry.
  logic [DEPTH-1:0] coal_match;
  logic             coal_any;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_coal
    assign coal_match[gi] = addr_match[gi] &&
                            !((state_reg == DRAIN) && (head_reg == PTR_W'(gi)));
  end

  assign {coal_any, coal_idx} = youngest_match(coal_match, head_reg);
  assign coal_hit = wb_write && coal_any;
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  // Write handshake: a coalescing write needs no free slot.
  assign wb_ready  = !full || coal_hit;
  assign wr_accept = wb_write && wb_ready;
  assign push      = wr_accept && !coal_hit;
  assign pop       = (state_reg == DRAIN) && pmem_resp;
  assign wr_idx    = coal_hit ? coal_idx : tail_reg;

  // Buffered hits are taken only when no response is being presented.
  assign hit_take = wb_read && rd_hit && !wb_resp &&
                    ((state_reg == IDLE) || (state_reg == DRAIN));

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // Valid bits: set on allocation at tail, cleared when the head drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
      end
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
      end
    end
  end

  // Entry address/data write port (allocation or in-place overwrite).
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      addr_reg[wr_idx] <= wb_address;
      data_reg[wr_idx] <= wb_wdata;
    end
  end

  // Registered read port for buffered hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_hit_reg <= 1'b0;
    end else begin
      resp_hit_reg <= hit_take;
    end
    if (hit_take) begin
      rdata_reg <= data_reg[rd_hit_idx];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and pmem strobes; read misses win over starting a drain.
  always_comb begin
    state_next   = state_reg;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = wb_address;
    case (state_reg)
      IDLE: begin
        if (wb_read && !rd_hit && !wb_resp) begin
          state_next = READ;
        end else if (count_reg != '0) begin
          state_next = DRAIN;
        end
      end
      READ: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = addr_reg[head_reg];
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Miss data passes straight through in the pmem_resp cycle.
  assign wb_resp    = resp_hit_reg || ((state_reg == READ) && pmem_resp);
  assign wb_rdata   = (state_reg == READ) ? pmem_rdata : rdata_reg;
  assign pmem_wdata = data_reg[head_reg];

endmodule

// File: doc/ewb_queue.md
Name: ewb_queue

Overview:
- Multi-entry eviction write buffer between the L2 cache and physical memory. Parametrised successor to the single-entry EWB datapath.
- Buffers up to DEPTH dirty victim lines in a circular FIFO and serves read hits from buffered data.
- Forwards read misses to pmem and drains entries to pmem in FIFO order under its own controller FSM.

Parameters:
- DEPTH, 4, number of line entries; power of two, at least 2.
- LINE_W, 256, line width in bits.
- ADDR_W, 32, address width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_write  in  1  upstream pushes an evicted line.
- wb_read  in  1  upstream line read; held high until wb_resp.
- wb_address  in  ADDR_W  line address for read or write.
- wb_wdata  in  LINE_W  evicted line data.
- wb_ready  out  1  write is accepted this cycle if wb_write && wb_ready.
- wb_resp  out  1  read complete; one-cycle pulse.
- wb_rdata  out  LINE_W  read data; valid while wb_resp=1.
- wb_empty  out  1  no valid entries.
- pmem_read  out  1  memory read request.
- pmem_write  out  1  memory write request.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data (head entry).
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory transaction done.

Behaviour:
- Storage and pointers:
  - Per entry: valid, addr, data.
  - head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); wb_empty = (count==0).
- Reset:
  - All valid bits, head, tail and count cleared; FSM goes to IDLE.
  - Outputs after reset: wb_resp=0, pmem_read=0, pmem_write=0, wb_ready=1, wb_empty=1.
  - pmem_address and wb_rdata are don't-care while their strobes are low.
  - Reset mid-transaction abandons it; buffered lines are lost.
- Write:
  - wb_ready = !full, or a coalescing hit (see Optional Feature).
  - On acceptance the line is stored at tail; tail and count increment at the next edge.
  - Write accept and pop in the same cycle leave count unchanged.
- Read hit check:
  - Combinational compare of wb_address against all valid entries as they stand at the start of the cycle.
  - A write accepted in the same cycle is not visible to the lookup.
  - If several entries match, the youngest (closest to tail) wins.
- Read hit:
  - Sampled in IDLE or DRAIN when wb_resp=0.
  - Registered: wb_resp=1 and wb_rdata=entry data on the following cycle, with no pmem access.
  - A wb_read seen while wb_resp=1 is ignored.
- FSM:
  - IDLE, when wb_read && !hit && !wb_resp:
    - Go to READ.
    - Read misses take priority over starting a drain.
  - IDLE, else if count>0: go to DRAIN.
  - READ:
    - pmem_read=1, pmem_address=wb_address.
    - On pmem_resp: wb_resp=1 and wb_rdata=pmem_rdata in the same cycle (combinational), then go to IDLE.
  - DRAIN:
    - pmem_write=1, pmem_address=head.addr, pmem_wdata=head.data.
    - On pmem_resp: clear head.valid, increment head, decrement count, go to IDLE.
    - A drain in progress always completes.
    - A read miss arriving during DRAIN waits, then is re-checked in IDLE.
- The head entry is never modified while in DRAIN; writes matching it allocate a new entry.
- pmem_read and pmem_write are never both high.

Optional Feature:
- Macro: EWB_COALESCE_EN.
- Defined:
  - A write whose address matches a valid entry (other than the head while in DRAIN) overwrites that entry's data in place.
  - No allocation, tail and count unchanged, and wb_ready=1 even when full.
- Undefined:
  - Every accepted write allocates a new entry.
  - Duplicate addresses may coexist; the youngest-match read rule applies.

Test Plan:
- Reset, then write A=0x100 (data 0xAA..), then wb_read 0x100 → wb_resp one cycle later with 0xAA.., no pmem_read; the drain to 0x100 follows.
- Write 4 distinct lines with pmem_resp held low → wb_ready=0 after the 4th; one pmem_resp → count=3, wb_ready=1; entries drain in order 0x100, 0x120, 0x140, 0x160.
- Read miss 0x800 while IDLE with count=2 → pmem_read issued before any pmem_write; wb_resp in the same cycle as pmem_resp, with wb_rdata=pmem_rdata.
- Read miss arriving mid-DRAIN → pmem_write completes first, then pmem_read 0x800; pmem_read and pmem_write never both high.
- Write 0x200 twice with data D1 then D2, then read 0x200 → returns D2. Count=1 with EWB_COALESCE_EN; count=2 without.
- Assert rst during READ and during DRAIN → next cycle pmem_read=0, pmem_write=0, wb_empty=1, wb_ready=1.
